quad_decoder: RTL

QUAD_DECODER -- requirements
Module: quad_decoder

---
 rtl/quad_pkg.sv | 39 +++
 rtl/quad_filter.sv | 69 ++++++
 rtl/quad_decoder.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/quad_pkg.sv
// rtl/quad_pkg.sv - shared types, accumulator limits and step classifier for the quadrature decoder
package quad_pkg;

    localparam int ACC_W = 8;
    localparam logic signed [ACC_W-1:0] ACC_MAX = 8'sh7F;
    localparam logic signed [ACC_W-1:0] ACC_MIN = 8'sh80;

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_CW,
        STEP_CCW,
        STEP_ERR
    } step_e;

    // Low two bits of each primed state are the AB value it represents.
    typedef enum logic [2:0] {
        S00      = 3'b000,
        S01      = 3'b001,
        S11      = 3'b011,
        S10      = 3'b010,
        UNPRIMED = 3'b100
    } dec_state_e;

    function automatic step_e classify(input logic [1:0] cur, input logic [1:0] nxt);
        logic [1:0] cw_ab;
        logic [1:0] ccw_ab;
        cw_ab  = {cur[0], ~cur[1]};
        ccw_ab = {~cur[0], cur[1]};
        if (nxt == cur)
            return STEP_NONE;
        else if (nxt == cw_ab)
            return STEP_CW;
        else if (nxt == ccw_ab)
            return STEP_CCW;
        else
            return STEP_ERR;
    endfunction

endpackage

// File: rtl/quad_filter.sv
// rtl/quad_filter.sv - 2-FF synchronizer plus stability filter for one quadrature phase
module quad_filter
    import quad_pkg::*;
#(
    parameter int unsigned FILT_LEN = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q,
    output logic o_valid
);

    localparam logic [7:0] LAST = 8'(FILT_LEN - 1);

    logic       r_sync1;
    logic       r_sync2;
    logic       r_q;
    logic       r_valid;
    logic [1:0] r_fill;
    logic [7:0] r_cnt;
    logic       w_cnt_done;

    assign w_cnt_done = (r_cnt == LAST);

    // Before the first acceptance the filter tracks the input and only
    // declares itself valid once it has held steady for FILT_LEN cycles;
    // r_fill keeps the stale reset contents of the synchronizer out of that.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_q     <= 1'b0;
            r_valid <= 1'b0;
            r_fill  <= 2'b00;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_d;
            r_sync2 <= r_sync1;
            r_fill  <= {r_fill[0], 1'b1};
            if (!r_fill[1]) begin
                r_cnt <= '0;
            end else if (!r_valid) begin
                if (r_sync2 != r_q) begin
                    r_q   <= r_sync2;
                    r_cnt <= '0;
                end else if (w_cnt_done) begin
                    r_valid <= 1'b1;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end else if (r_sync2 != r_q) begin
                if (w_cnt_done) begin
                    r_q   <= r_sync2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_q     = r_q;
    assign o_valid = r_valid;

endmodule

// File: rtl/quad_decoder.sv
// rtl/quad_decoder.sv - x4 quadrature decoder with position, read-and-clear delta and error count
module quad_decoder
    import quad_pkg::*;
#(
    parameter int unsigned FILT_LEN = 4,
    parameter int unsigned POS_W    = 16,
    parameter int unsigned WRAP     = 1
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_quad_a,
    input  logic                    i_quad_b,
    input  logic                    i_clr,
    input  logic                    i_rd_req,
    output logic signed [POS_W-1:0] o_pos,
    output logic                    o_step_cw,
    output logic                    o_step_ccw,
    output logic                    o_dir,
    output logic signed [7:0]       o_delta_out,
    output logic                    o_rd_valid,
    output logic                    o_err,
    output logic [7:0]              o_err_cnt
);

    localparam logic signed [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
    localparam logic signed [POS_W-1:0] POS_MIN = {1'b1, {(POS_W-1){1'b0}}};
    localparam logic signed [POS_W-1:0] POS_ONE = {{(POS_W-1){1'b0}}, 1'b1};

    logic                    w_a;
    logic                    w_b;
    logic                    w_va;
    logic                    w_vb;
    logic [1:0]              r_ab;
    logic                    r_ab_vld;
    dec_state_e              r_state;
    dec_state_e              w_next;
    step_e                   w_step;
    logic signed [POS_W-1:0] w_pos_nxt;
    logic signed [7:0]       w_acc_nxt;
    logic signed [7:0]       w_acc_fresh;

    logic signed [POS_W-1:0] r_pos;
    logic signed [7:0]       r_acc;
    logic signed [7:0]       r_delta;
    logic                    r_rd_pend;
    logic                    r_rd_valid;
    logic                    r_dir;
    logic                    r_step_cw;
    logic                    r_step_ccw;
    logic                    r_err;
    logic [7:0]              r_err_cnt;

    quad_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_quad_a),
        .o_q     (w_a),
        .o_valid (w_va)
    );

    quad_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_quad_b),
        .o_q     (w_b),
        .o_valid (w_vb)
    );

    // Pipeline stage between filter and decoder sets the fixed step latency.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ab     <= 2'b00;
            r_ab_vld <= 1'b0;
        end else begin
            r_ab     <= {w_a, w_b};
            r_ab_vld <= w_va & w_vb;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_state <= UNPRIMED;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_step = STEP_NONE;
        if (r_ab_vld) begin
            w_next = dec_state_e'({1'b0, r_ab});
            if (r_state != UNPRIMED)
                w_step = classify(r_state[1:0], r_ab);
        end
    end

    always_comb begin
        w_pos_nxt   = r_pos;
        w_acc_nxt   = r_acc;
        w_acc_fresh = 8'sh00;
        if (w_step == STEP_CW) begin
            if (WRAP != 0 || r_pos != POS_MAX)
                w_pos_nxt = r_pos + POS_ONE;
            if (r_acc != ACC_MAX)
                w_acc_nxt = r_acc + 8'sh01;
            w_acc_fresh = 8'sh01;
        end else if (w_step == STEP_CCW) begin
            if (WRAP != 0 || r_pos != POS_MIN)
                w_pos_nxt = r_pos - POS_ONE;
            if (r_acc != ACC_MIN)
                w_acc_nxt = r_acc - 8'sh01;
            w_acc_fresh = 8'shFF;
        end
    end

    // A read latches the accumulator one cycle after the request so a step
    // decoded on the request edge is still included.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pos      <= '0;
            r_acc      <= '0;
            r_delta    <= '0;
            r_rd_pend  <= 1'b0;
            r_rd_valid <= 1'b0;
            r_dir      <= 1'b0;
            r_step_cw  <= 1'b0;
            r_step_ccw <= 1'b0;
            r_err      <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            r_step_cw  <= (w_step == STEP_CW);
            r_step_ccw <= (w_step == STEP_CCW);
            r_err      <= (w_step == STEP_ERR);
            if (w_step == STEP_CW)
                r_dir <= 1'b1;
            else if (w_step == STEP_CCW)
                r_dir <= 1'b0;
            r_rd_pend  <= i_rd_req;
            r_rd_valid <= r_rd_pend;
            if (i_clr) begin
                r_pos     <= '0;
                r_acc     <= '0;
                r_err_cnt <= '0;
                if (r_rd_pend)
                    r_delta <= '0;
            end else begin
                r_pos <= w_pos_nxt;
                if (w_step == STEP_ERR && r_err_cnt != 8'hFF)
                    r_err_cnt <= r_err_cnt + 8'd1;
                if (r_rd_pend) begin
                    r_delta <= r_acc;
                    r_acc   <= w_acc_fresh;
                end else begin
                    r_acc <= w_acc_nxt;
                end
            end
        end
    end

    assign o_pos       = r_pos;
    assign o_step_cw   = r_step_cw;
    assign o_step_ccw  = r_step_ccw;
    assign o_dir       = r_dir;
    assign o_delta_out = r_delta;
    assign o_rd_valid  = r_rd_valid;
    assign o_err       = r_err;
    assign o_err_cnt   = r_err_cnt;

endmodule
